// File: rtl/prog_loader_if.sv
// Byte-stream loader bus: byte source handshake on one side, instruction-memory
// write port and load status on the other. The loader uses the slave modport.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_data;
    logic [ADDR_W:0]   words;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_run;

    // Byte source / system side
    modport master (
        output start, in_valid, in_data,
        input  in_ready, im_we, im_addr, im_data, words, busy, done, err, cpu_run
    );

    // Loader side
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, im_we, im_addr, im_data, words, busy, done, err, cpu_run
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles big-endian byte pairs into 16-bit instructions and
// writes them to instruction memory until the halt word or the last address.
// The CPU is held in reset (cpu_run=0) until a load completes.
// Optional checksum byte after the program: define LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [7:0]        hi_q,    hi_d;
    logic [7:0]        lo_q,    lo_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q,   sum_d;
`endif

    logic ready;
    logic accept;
    logic last_word;
    state_t term_state;

    assign accept    = ready & bus.in_valid;
    assign last_word = ({hi_q, lo_q} == HALT_WORD) || (addr_q == '1);
`ifdef LOADER_CHECKSUM_EN
    assign term_state = S_CSUM;
`else
    assign term_state = S_DONE;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: address, word count, byte latches (and running sum)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            words_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            addr_q  <= addr_d;
            words_q <= words_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_HI;
                    addr_d  = '0;
                    words_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + bus.in_data;
`endif
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    lo_d    = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + bus.in_data;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_q + WORDS_ONE;
                // The last address terminates instead of wrapping to 0.
                if (last_word) begin
                    state_d = term_state;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = ((sum_q + bus.in_data) == 8'h00) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; every output is a function of registered state only
    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_HI, S_LO: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:     ready = 1'b1;
`endif
            default:    ready = 1'b0;
        endcase
    end

    assign bus.in_ready = ready;
    assign bus.im_we    = (state_q == S_WRITE);
    assign bus.im_addr  = addr_q;
    assign bus.im_data  = {hi_q, lo_q};
    assign bus.words    = words_q;
    assign bus.busy     = ready || (state_q == S_WRITE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.cpu_run  = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    assign bus.err      = (state_q == S_ERR);
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes 16-bit instructions into the CPU's instruction memory. It is the writer side of the instruction-fetch path: the CPU reads one 16-bit word per PC value, and this block fills those words before execution. It holds the CPU in reset until a complete program, terminated by the halt word, has been written. It sits between an external byte source (testbench or UART receiver) and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words.
- HALT_WORD, 16'h0000, instruction that terminates the load (the CPU halt encoding).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  program byte, high byte of each instruction first.
- in_ready  output  1  block accepts a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  ADDR_W  write address.
- im_data  output  16  write data.
- words  output  ADDR_W+1  number of words written in the current load.
- busy  output  1  load in progress (HI, LO, WRITE or CSUM).
- done  output  1  load completed successfully.
- err  output  1  load failed (checksum build only).
- cpu_run  output  1  release for the CPU; 0 holds the CPU in reset.

## Operation
- States: IDLE, HI, LO, WRITE, CSUM, DONE, ERR.
- IDLE: in_ready=0. start=1 → HI; addr and words cleared to 0.
- HI: in_ready=1. Accepted byte (in_valid & in_ready) → high byte latched, → LO.
- LO: in_ready=1. Accepted byte → low byte latched, → WRITE.
- WRITE: in_ready=0; im_we=1 with im_addr=addr and im_data={hi,lo}; words increments by 1.
  - Word equals HALT_WORD, or addr equals 2^ADDR_W−1 → CSUM if LOADER_CHECKSUM_EN, else DONE.
  - Otherwise addr increments by 1, → HI.
- DONE: done=1, cpu_run=1, in_ready=0. start=1 → HI with addr and words cleared, done and cpu_run dropping next cycle.
- ERR: err=1, cpu_run=0, in_ready=0. start behaves as in DONE.
- start is ignored in HI, LO, WRITE and CSUM; loads are not aborted except by reset.
- in_ready is a function of state only; a byte presented in IDLE, WRITE, DONE or ERR is not consumed.
- A capacity overflow (no halt within 2^ADDR_W words) ends the load normally after the last address is written; the last word is written as supplied.

## Timing
- Reset (asynchronous): state IDLE; in_ready=0, im_we=0, im_addr=0, im_data=0, words=0, busy=0, done=0, err=0, cpu_run=0.
- Minimum cost per instruction: 3 cycles (HI, LO, WRITE) with in_valid held high.
- im_we is registered and asserts for exactly the cycle the FSM is in WRITE; im_addr and im_data remain stable through that cycle.
- done and cpu_run assert on the first cycle in DONE: one cycle after the halt-word WRITE, or one cycle after the checksum byte is accepted.
- Reset asserted mid-load aborts immediately. Memory contents already written remain; cpu_run=0.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) is kept of every accepted program byte.
  - After the terminating WRITE, CSUM asserts in_ready and accepts one byte.
  - If that byte equals the two's complement of the sum (sum + byte ≡ 0 mod 256) → DONE; otherwise → ERR.
  - The sum clears on start.
- LOADER_CHECKSUM_EN undefined:
  - No CSUM state and no sum register; err is tied to 0.
  - Termination goes directly to DONE.

## Test plan
- Reset mid-stream: after 3 bytes are accepted, pulse rst_n low → all outputs 0 immediately; state IDLE; next start begins at addr 0.
- Basic load: start, then bytes 81,24, 16,53, 00,00 with in_valid constant → writes 0x8124@0, 0x1653@1, 0x0000@2; im_we high on exactly 3 cycles; words=3; done=cpu_run=1 on the cycle after the third write.
- Backpressure and gaps: same stream with in_valid toggled every other cycle → identical writes; in_ready=0 during every WRITE cycle; no byte lost or duplicated.
- Overflow: 256 non-halt words → last write at addr 0xFF; words=256; DONE with no wrap to addr 0.
- Restart: start pulsed in DONE → done and cpu_run drop the next cycle; new load begins at addr 0 with words=0. start pulsed during LO → ignored.
- Checksum (LOADER_CHECKSUM_EN): stream 01,02,00,00 followed by FD → DONE. The same stream followed by FC → ERR with err=1 and cpu_run=0.
